// File: rtl/key_step_conditioner_if.sv
// key_step_conditioner_if: raw key inputs and conditioned key strobes
interface key_step_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] pressed;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] step;
    modport master (output key_n, input pressed, press_pulse, release_pulse, step);
    modport slave (input key_n, output pressed, press_pulse, release_pulse, step);
endinterface

// File: rtl/key_step_conditioner.sv
// key_step_conditioner: synchronised, debounced keys with edge strobes and hold-to-repeat steps
module key_step_conditioner #(
    parameter int NUM_KEYS = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter logic [NUM_KEYS-1:0] REPEAT_EN = '0
) (
    input logic CLOCK_50,
    input logic reset,
    key_step_conditioner_if.slave keys
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW = $clog2(TMAX) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST = TW'(REPEAT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
    logic [NUM_KEYS-1:0] sync1, sync2, flip, level_next, rep_strobe;
    // two-flop synchroniser; resets to the released level
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= keys.key_n;
            sync2 <= sync1;
        end
    end
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic sample, strobe;
        logic [DW-1:0] db_cnt;
        logic [TW-1:0] timer, timer_next;
        state_t state, state_next;
        assign sample = !sync2[i];
        assign flip[i] = (sample != keys.pressed[i]) && (db_cnt == DB_LAST);
        assign level_next[i] = keys.pressed[i] ^ flip[i];
        assign rep_strobe[i] = strobe;
        // count consecutive samples that disagree with the accepted level
        always_ff @(posedge CLOCK_50) begin
            if (reset)
                db_cnt <= '0;
            else
                db_cnt <= (sample == keys.pressed[i] || flip[i]) ? '0 : db_cnt + 1'b1;
        end
        // repeat FSM state and timer; channels without repeat stay idle
        always_ff @(posedge CLOCK_50) begin
            if (reset || !REPEAT_EN[i]) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                state <= state_next;
                timer <= timer_next;
            end
        end
        // next state follows the level being committed this edge, so a release wins over expiry
        always_comb begin
            state_next = state;
            timer_next = timer + 1'b1;
            if (!level_next[i]) begin
                state_next = IDLE;
                timer_next = '0;
            end else if (state == IDLE) begin
                state_next = flip[i] ? HOLD : IDLE;
                timer_next = '0;
            end else if (state == HOLD && timer == HOLD_LAST) begin
                state_next = REPEAT;
                timer_next = '0;
            end else if (state == REPEAT && timer == REP_LAST) begin
                timer_next = '0;
            end
        end
        // repeat strobe on timer expiry while the key remains held
        always_comb begin
            strobe = REPEAT_EN[i] && level_next[i] &&
                     ((state == HOLD && timer == HOLD_LAST) || (state == REPEAT && timer == REP_LAST));
        end
    end
    // registered outputs; pulses appear together with the new debounced level
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            keys.pressed <= '0;
            keys.press_pulse <= '0;
            keys.release_pulse <= '0;
            keys.step <= '0;
        end else begin
            keys.pressed <= level_next;
            keys.press_pulse <= flip & level_next;
            keys.release_pulse <= flip & ~level_next;
            keys.step <= (flip & level_next) | rep_strobe;
        end
    end
endmodule

// File: tb/tb_key_step_conditioner.sv
// tb_key_step_conditioner: directed key scenarios checked against a sample-window behavioural model
module tb_key_step_conditioner;
    localparam int NK = 4;
    localparam int DB = 4;
    localparam int HOLD = 10;
    localparam int REP = 3;
    localparam logic [NK-1:0] REN = 4'b0010;
    logic CLOCK_50 = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    key_step_conditioner_if #(.NUM_KEYS(NK)) keys ();
    key_step_conditioner #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP),
        .REPEAT_EN(REN)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .keys(keys.slave)
    );
    always #10 CLOCK_50 = ~CLOCK_50;
    task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask
    // model: a level is accepted once the last DB synchronised samples all disagree with it;
    // steps fall at the press cycle, then HOLD later, then every REP while still held
    logic [NK-1:0] m_pressed = '0, m_pp = '0, m_rp = '0, m_step = '0;
    logic [DB+1:0] win [NK];
    int press_cyc [NK];
    int cyc = 0;
    bit armed = 1'b0;
    always @(posedge CLOCK_50) begin
        logic nxt;
        int d;
        cyc++;
        for (int k = 0; k < NK; k++) begin
            if (reset) begin
                win[k] = '0;
                m_pressed[k] = 1'b0;
                m_pp[k] = 1'b0;
                m_rp[k] = 1'b0;
                m_step[k] = 1'b0;
                press_cyc[k] = -1;
            end else begin
                win[k] = {win[k][DB:0], ~keys.key_n[k]};
                nxt = (win[k][DB+1:2] == {DB{~m_pressed[k]}}) ? ~m_pressed[k] : m_pressed[k];
                m_pp[k] = nxt & ~m_pressed[k];
                m_rp[k] = ~nxt & m_pressed[k];
                m_pressed[k] = nxt;
                if (m_pp[k]) press_cyc[k] = cyc;
                d = cyc - press_cyc[k];
                m_step[k] = m_pp[k] || (REN[k] && nxt && press_cyc[k] >= 0 && d >= HOLD && (d - HOLD) % REP == 0);
            end
        end
        armed = 1'b1;
    end
    // every-cycle comparison against the model
    always @(negedge CLOCK_50) begin
        if (armed) begin
            chk("pressed", keys.pressed, m_pressed);
            chk("press_pulse", keys.press_pulse, m_pp);
            chk("release_pulse", keys.release_pulse, m_rp);
            chk("step", keys.step, m_step);
            checks++;
            if ((keys.press_pulse & keys.release_pulse) != '0) begin
                errors++;
                $display("FAIL both_pulses: got %b expected 0000", keys.press_pulse & keys.release_pulse);
            end
        end
    end
    initial begin
        keys.key_n = 4'hF;
        reset = 1'b1;
        tick(3);
        chk("reset_pressed", keys.pressed, 4'b0000);
        chk("reset_step", keys.step, 4'b0000);
        reset = 1'b0;
        tick(4);
        // clean press on key 0
        keys.key_n[0] = 1'b0;
        tick(5);
        chk("press_early", keys.pressed, 4'b0000);
        tick(1);
        chk("press_level", keys.pressed, 4'b0001);
        chk("press_pulse", keys.press_pulse, 4'b0001);
        chk("press_step", keys.step, 4'b0001);
        chk("model_press_pulse", m_pp, 4'b0001);
        tick(1);
        chk("press_pulse_once", keys.press_pulse, 4'b0000);
        chk("press_held", keys.pressed, 4'b0001);
        tick(3);
        keys.key_n[0] = 1'b1;
        tick(5);
        chk("release_early", keys.release_pulse, 4'b0000);
        tick(1);
        chk("release_pulse", keys.release_pulse, 4'b0001);
        chk("release_level", keys.pressed, 4'b0000);
        chk("model_release_pulse", m_rp, 4'b0001);
        tick(1);
        chk("release_once", keys.release_pulse, 4'b0000);
        tick(3);
        // bounce shorter than the debounce window
        for (int i = 0; i < 10; i++) begin
            keys.key_n[0] = i[0];
            tick(2);
        end
        keys.key_n[0] = 1'b1;
        tick(8);
        chk("bounce_level", keys.pressed, 4'b0000);
        // keys 0 and 1 held together; only key 1 repeats
        keys.key_n = 4'b1100;
        tick(6);
        chk("dual_press", keys.press_pulse, 4'b0011);
        chk("dual_step", keys.step, 4'b0011);
        tick(9);
        chk("pre_first_repeat", keys.step, 4'b0000);
        tick(1);
        chk("first_repeat", keys.step, 4'b0010);
        chk("model_first_repeat", m_step, 4'b0010);
        tick(3);
        chk("second_repeat", keys.step, 4'b0010);
        tick(21);
        keys.key_n = 4'hF;
        tick(3);
        chk("last_repeat", keys.step, 4'b0010);
        tick(3);
        chk("race_step", keys.step, 4'b0000);
        chk("race_release", keys.release_pulse, 4'b0011);
        chk("model_race_step", m_step, 4'b0000);
        tick(6);
        // reset while key 1 is in repeat
        keys.key_n[1] = 1'b0;
        tick(6);
        chk("rst_case_press", keys.press_pulse, 4'b0010);
        tick(12);
        reset = 1'b1;
        tick(2);
        chk("midreset_pressed", keys.pressed, 4'b0000);
        chk("midreset_step", keys.step, 4'b0000);
        reset = 1'b0;
        tick(5);
        chk("after_reset_early", keys.pressed, 4'b0000);
        tick(1);
        chk("after_reset_press", keys.press_pulse, 4'b0010);
        chk("after_reset_step", keys.step, 4'b0010);
        tick(9);
        chk("after_reset_gap", keys.step, 4'b0000);
        tick(1);
        chk("after_reset_repeat", keys.step, 4'b0010);
        tick(3);
        chk("after_reset_repeat2", keys.step, 4'b0010);
        keys.key_n = 4'hF;
        tick(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
